// File: rtl/mdu_sched_if.sv
// Signal bundle between the issue logic, the mult/div engines and the MDU sequencer.
// Handshake: an op is taken on a rising clk edge when op_valid=1, op!=NOP, flush_i=0 and stall_o=0;
// the issuer holds op/src_a/src_b steady while stall_o is high.
interface mdu_sched_if;
    logic        op_valid;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush_i;
    logic        stall_o;
    logic [1:0]  mult_op;
    logic [1:0]  div_op;
    logic [31:0] eng_a;
    logic [31:0] eng_b;
    logic        mult_done;
    logic        div_done;
    logic [63:0] mult_res;
    logic [63:0] div_res;
    logic [31:0] hi_o;
    logic [31:0] lo_o;
    logic        busy_o;
    logic        err_timeout;
    logic [1:0]  state_o;

    modport slave (
        input  op_valid, op, src_a, src_b, flush_i,
        input  mult_done, div_done, mult_res, div_res,
        output stall_o, mult_op, div_op, eng_a, eng_b,
        output hi_o, lo_o, busy_o, err_timeout, state_o
    );

    modport master (
        output op_valid, op, src_a, src_b, flush_i,
        output mult_done, div_done, mult_res, div_res,
        input  stall_o, mult_op, div_op, eng_a, eng_b,
        input  hi_o, lo_o, busy_o, err_timeout, state_o
    );
endinterface

// File: rtl/mdu_sched.sv
// Sequencer for the multi-cycle mult/div engines: starts one op at a time, owns HI/LO,
// stalls issue while an op is in flight, and handles flush, divide-by-zero and a watchdog.
module mdu_sched #(
    parameter int TIMEOUT     = 64,
    parameter bit DIV0_BYPASS = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    mdu_sched_if.slave bus
);
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT_M = 2'd1,
        S_WAIT_D = 2'd2,
        S_DRAIN  = 2'd3
    } state_e;

    state_e           state_q, state_d;
    logic [31:0]      hi_q, hi_d, lo_q, lo_d;
    logic [31:0]      eng_a_q, eng_a_d, eng_b_q, eng_b_d;
    logic [1:0]       mult_op_q, mult_op_d, div_op_q, div_op_d;
    logic             sel_div_q, sel_div_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic        op_req, stall, accept, start_cycle, done_seen, timeout_hit, div_by_zero;
    logic [63:0] eng_res;

    assign op_req      = bus.op_valid && (bus.op != OP_NOP);
    assign stall       = op_req && (state_q != S_IDLE);
    assign accept      = op_req && !bus.flush_i && !stall;
    assign div_by_zero = DIV0_BYPASS && (bus.src_b == 32'd0);
    // Done from the previous op is still held during the start cycle, so it is ignored there.
    assign start_cycle = (mult_op_q != 2'b00) || (div_op_q != 2'b00);
    assign done_seen   = (sel_div_q ? bus.div_done : bus.mult_done) && !start_cycle;
    assign eng_res     = sel_div_q ? bus.div_res : bus.mult_res;
    assign timeout_hit = (cnt_q == CNT_LAST);

    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        eng_a_d   = eng_a_q;
        eng_b_d   = eng_b_q;
        mult_op_d = 2'b00;
        div_op_d  = 2'b00;
        sel_div_d = sel_div_q;
        cnt_d     = cnt_q + CNT_W'(1);
        err_d     = err_q;

        unique case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (accept) begin
                    case (bus.op)
                        OP_MULT, OP_MULTU: begin
                            eng_a_d   = bus.src_a;
                            eng_b_d   = bus.src_b;
                            mult_op_d = (bus.op == OP_MULT) ? 2'b10 : 2'b01;
                            sel_div_d = 1'b0;
                            state_d   = S_WAIT_M;
                        end
                        OP_DIV, OP_DIVU: begin
                            if (div_by_zero) begin
                                hi_d = bus.src_a;
                                lo_d = 32'hFFFF_FFFF;
                            end else begin
                                eng_a_d   = bus.src_a;
                                eng_b_d   = bus.src_b;
                                div_op_d  = (bus.op == OP_DIV) ? 2'b10 : 2'b01;
                                sel_div_d = 1'b1;
                                state_d   = S_WAIT_D;
                            end
                        end
                        OP_MTHI: hi_d = bus.src_a;
                        OP_MTLO: lo_d = bus.src_a;
                        default: ;
                    endcase
                end
            end
            S_WAIT_M, S_WAIT_D: begin
                // Flush beats a same-cycle done: the result is dropped.
                if (bus.flush_i) begin
                    if (done_seen) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DRAIN;
                        cnt_d   = '0;
                    end
                end else if (done_seen) begin
                    {hi_d, lo_d} = eng_res;
                    state_d      = S_IDLE;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_DRAIN: begin
                if (done_seen) begin
                    state_d = S_IDLE;
                end else if (timeout_hit) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            hi_q      <= '0;
            lo_q      <= '0;
            eng_a_q   <= '0;
            eng_b_q   <= '0;
            mult_op_q <= 2'b00;
            div_op_q  <= 2'b00;
            sel_div_q <= 1'b0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            eng_a_q   <= eng_a_d;
            eng_b_q   <= eng_b_d;
            mult_op_q <= mult_op_d;
            div_op_q  <= div_op_d;
            sel_div_q <= sel_div_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
        end
    end

    assign bus.stall_o     = stall;
    assign bus.mult_op     = mult_op_q;
    assign bus.div_op      = div_op_q;
    assign bus.eng_a       = eng_a_q;
    assign bus.eng_b       = eng_b_q;
    assign bus.hi_o        = hi_q;
    assign bus.lo_o        = lo_q;
    assign bus.busy_o      = (state_q != S_IDLE);
    assign bus.err_timeout = err_q;
    assign bus.state_o     = state_q;
endmodule

// File: tb/tb_mdu_sched.sv
// Bench for mdu_sched: behavioural mult/div engines, an architectural HI/LO model,
// and a monitor that checks start pulses and HI/LO reads against expected queues.
module tb_mdu_sched;
    localparam int TMO = 8;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam logic [2:0] OP_RD    = 3'd7;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mdu_sched_if bus();

    mdu_sched #(.TIMEOUT(TMO), .DIV0_BYPASS(1'b1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // ---------------- scoreboard state ----------------
    int          checks = 0;
    int          errors = 0;
    logic [67:0] start_q[$];
    logic [63:0] rd_q[$];
    logic [31:0] m_hi, m_lo, sv_hi, sv_lo;
    int          mult_lat_force = 0;
    int          div_lat_force  = 0;
    bit          hang = 1'b0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic: MIPS-style {hi, lo}; division gives {remainder, quotient}.
    function automatic logic [63:0] mdu_ref(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] ua, ub, p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        p  = '0;
        if ((op == OP_DIV || op == OP_DIVU) && b == 32'd0) begin
            p = {a, 32'hFFFF_FFFF};
        end else begin
            case (op)
                OP_MULT:  p = 64'(sa * sb);
                OP_MULTU: p = ua * ub;
                OP_DIV: begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
                OP_DIVU:  p = {a % b, a / b};
                default:  p = '0;
            endcase
        end
        return p;
    endfunction

    // ---------------- engine models ----------------
    initial begin : mult_engine
        int          rem;
        logic        go;
        logic [63:0] pend;
        rem = 0;
        pend = '0;
        bus.mult_done = 1'b0;
        bus.mult_res  = '0;
        forever begin
            @(negedge clk);
            go = (bus.mult_op != 2'b00);
            if (go) pend = mdu_ref((bus.mult_op == 2'b10) ? OP_MULT : OP_MULTU, bus.eng_a, bus.eng_b);
            @(posedge clk);
            #1;
            if (go) begin
                bus.mult_done = 1'b0;
                rem = ((mult_lat_force != 0) ? mult_lat_force : int'($urandom_range(6, 2))) - 1;
            end else if (rem > 0) begin
                rem--;
                if (rem == 0 && !hang) begin
                    bus.mult_done = 1'b1;
                    bus.mult_res  = pend;
                end
            end
        end
    end

    initial begin : div_engine
        int          rem;
        logic        go;
        logic [63:0] pend;
        rem = 0;
        pend = '0;
        bus.div_done = 1'b0;
        bus.div_res  = '0;
        forever begin
            @(negedge clk);
            go = (bus.div_op != 2'b00);
            if (go) pend = mdu_ref((bus.div_op == 2'b10) ? OP_DIV : OP_DIVU, bus.eng_a, bus.eng_b);
            @(posedge clk);
            #1;
            if (go) begin
                bus.div_done = 1'b0;
                rem = ((div_lat_force != 0) ? div_lat_force : int'($urandom_range(6, 2))) - 1;
            end else if (rem > 0) begin
                rem--;
                if (rem == 0 && !hang) begin
                    bus.div_done = 1'b1;
                    bus.div_res  = pend;
                end
            end
        end
    end

    // ---------------- monitor ----------------
    initial begin : monitor
        logic [67:0] exp_s;
        logic [63:0] exp_r;
        forever begin
            @(negedge clk);
            if (!rst && (bus.mult_op != 2'b00 || bus.div_op != 2'b00)) begin
                if (start_q.size() == 0) begin
                    check("unexpected_start", {bus.mult_op, bus.div_op}, 4'b0000);
                end else begin
                    exp_s = start_q.pop_front();
                    check("start_pulse", {bus.mult_op, bus.div_op, bus.eng_a, bus.eng_b}, exp_s);
                end
            end
            if (!rst && bus.op_valid && bus.op == OP_RD && !bus.stall_o && !bus.flush_i) begin
                if (rd_q.size() == 0) begin
                    check("unexpected_read", 1'b1, 1'b0);
                end else begin
                    exp_r = rd_q.pop_front();
                    check("hilo_read", {bus.hi_o, bus.lo_o}, exp_r);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called at posedge+1; returns at posedge+1 of the cycle after acceptance.
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         output int waits);
        logic is_div, is_eng;
        waits  = 0;
        is_div = (op == OP_DIV) || (op == OP_DIVU);
        is_eng = (op == OP_MULT) || (op == OP_MULTU) || (is_div && b != 32'd0);
        sv_hi  = m_hi;
        sv_lo  = m_lo;
        if (is_eng) begin
            start_q.push_back({(op == OP_MULT) ? 2'b10 : (op == OP_MULTU) ? 2'b01 : 2'b00,
                               (op == OP_DIV)  ? 2'b10 : (op == OP_DIVU)  ? 2'b01 : 2'b00,
                               a, b});
            {m_hi, m_lo} = mdu_ref(op, a, b);
        end else if (is_div) begin
            {m_hi, m_lo} = mdu_ref(op, a, b);
        end else if (op == OP_MTHI) begin
            m_hi = a;
        end else if (op == OP_MTLO) begin
            m_lo = a;
        end else if (op == OP_RD) begin
            rd_q.push_back({m_hi, m_lo});
        end
        bus.op_valid = 1'b1;
        bus.op       = op;
        bus.src_a    = a;
        bus.src_b    = b;
        @(negedge clk);
        while (bus.stall_o && waits < 200) begin
            waits++;
            @(negedge clk);
        end
        check("issue_accepted", bus.stall_o, 1'b0);
        @(posedge clk);
        #1;
        bus.op_valid = 1'b0;
        bus.op       = OP_NOP;
    endtask

    task automatic restore_model();
        m_hi = sv_hi;
        m_lo = sv_lo;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin : main
        int          w, cyc, sel;
        logic [2:0]  op;
        logic [31:0] a, b;
        logic        eng;

        rst = 1'b1;
        bus.op_valid = 1'b0;
        bus.op       = OP_NOP;
        bus.src_a    = '0;
        bus.src_b    = '0;
        bus.flush_i  = 1'b0;
        m_hi = '0;
        m_lo = '0;
        sv_hi = '0;
        sv_lo = '0;
        step(3);
        rst = 1'b0;

        check("rst_hi", bus.hi_o, 32'd0);
        check("rst_lo", bus.lo_o, 32'd0);
        check("rst_busy", bus.busy_o, 1'b0);
        check("rst_stall", bus.stall_o, 1'b0);
        check("rst_ops", {bus.mult_op, bus.div_op}, 4'b0000);
        check("rst_eng", {bus.eng_a, bus.eng_b}, 64'd0);
        check("rst_err", bus.err_timeout, 1'b0);

        // Signed MULT, latency 3: a read stalls through the done cycle.
        mult_lat_force = 3;
        issue(OP_MULT, 32'hFFFF_FFFF, 32'd2, w);
        issue(OP_RD, 32'd0, 32'd0, w);
        check("mult_rd_stall_cycles", w, 4);
        check("mult_hilo", {bus.hi_o, bus.lo_o}, 64'hFFFF_FFFF_FFFF_FFFE);

        // DIVU 100/7, then divide by zero bypass.
        div_lat_force = 4;
        issue(OP_DIVU, 32'd100, 32'd7, w);
        issue(OP_RD, 32'd0, 32'd0, w);
        check("divu_hi", bus.hi_o, 32'd2);
        check("divu_lo", bus.lo_o, 32'd14);
        issue(OP_DIV, 32'd5, 32'd0, w);
        check("div0_busy", bus.busy_o, 1'b0);
        check("div0_hilo", {bus.hi_o, bus.lo_o}, {32'd5, 32'hFFFF_FFFF});
        check("div0_no_pulse", bus.div_op, 2'b00);

        // Flush in the start cycle: DRAIN until done, result dropped.
        issue(OP_MULT, 32'd3, 32'd4, w);
        bus.flush_i = 1'b1;
        restore_model();
        step(1);
        bus.flush_i = 1'b0;
        cyc = 2;
        @(negedge clk);
        while (bus.busy_o && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("drain_busy_fall_cycle", cyc, 5);
        step(1);
        issue(OP_RD, 32'd0, 32'd0, w);

        // Flush coinciding with done: flush wins.
        issue(OP_MULT, 32'd6, 32'd7, w);
        step(3);
        bus.flush_i = 1'b1;
        restore_model();
        step(1);
        bus.flush_i = 1'b0;
        check("flush_on_done_idle", bus.busy_o, 1'b0);
        issue(OP_RD, 32'd0, 32'd0, w);

        // Flush in IDLE: the op is not taken.
        bus.op_valid = 1'b1;
        bus.op       = OP_MTHI;
        bus.src_a    = 32'hDEAD_BEEF;
        bus.flush_i  = 1'b1;
        step(1);
        bus.op_valid = 1'b0;
        bus.op       = OP_NOP;
        bus.flush_i  = 1'b0;
        check("idle_flush_hi", bus.hi_o, 32'd5);
        issue(OP_RD, 32'd0, 32'd0, w);

        // Back-to-back DIV then MULT.
        issue(OP_DIV, 32'hFFFF_FFEC, 32'd3, w);
        issue(OP_MULT, 32'h0001_0000, 32'h0001_0000, w);
        check("b2b_mult_stall_cycles", w, 5);
        issue(OP_RD, 32'd0, 32'd0, w);

        // Engine hang: watchdog fires, HI/LO untouched.
        hang = 1'b1;
        issue(OP_MULT, 32'd9, 32'd9, w);
        restore_model();
        cyc = 1;
        @(negedge clk);
        while (!bus.err_timeout && cyc < 50) begin
            @(negedge clk);
            cyc++;
        end
        check("timeout_cycle", cyc, TMO + 1);
        check("timeout_idle", bus.busy_o, 1'b0);
        step(1);
        hang = 1'b0;
        issue(OP_MTLO, 32'h0000_1234, 32'd0, w);
        check("mtlo_after_timeout", bus.lo_o, 32'h0000_1234);
        check("err_sticky", bus.err_timeout, 1'b1);
        issue(OP_RD, 32'd0, 32'd0, w);

        // Reset in WAIT_D; the late done must be ignored.
        div_lat_force = 5;
        issue(OP_DIVU, 32'd1000, 32'd3, w);
        step(1);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        m_hi = '0;
        m_lo = '0;
        check("midrst_hilo", {bus.hi_o, bus.lo_o}, 64'd0);
        check("midrst_busy", bus.busy_o, 1'b0);
        check("midrst_ops", {bus.mult_op, bus.div_op}, 4'b0000);
        check("midrst_eng", {bus.eng_a, bus.eng_b}, 64'd0);
        check("midrst_err", bus.err_timeout, 1'b0);
        step(8);
        check("late_done_ignored", {bus.hi_o, bus.lo_o}, 64'd0);
        issue(OP_RD, 32'd0, 32'd0, w);

        // Randomized mix.
        mult_lat_force = 0;
        div_lat_force  = 0;
        for (int i = 0; i < 150; i++) begin
            sel = int'($urandom_range(6, 0));
            op  = 3'(sel + 1);
            a   = $urandom;
            b   = $urandom;
            if ((op == OP_DIV || op == OP_DIVU) && $urandom_range(3, 0) == 0) b = 32'd0;
            if ((op == OP_DIV || op == OP_DIVU) && $urandom_range(1, 0) == 0) b = b & 32'h0000_00FF;
            eng = (op == OP_MULT) || (op == OP_MULTU) ||
                  ((op == OP_DIV || op == OP_DIVU) && b != 32'd0);
            issue(op, a, b, w);
            if (eng && $urandom_range(7, 0) == 0) begin
                bus.flush_i = 1'b1;
                restore_model();
                step(1);
                bus.flush_i = 1'b0;
            end
            if ($urandom_range(2, 0) == 0) issue(OP_RD, 32'd0, 32'd0, w);
            if ($urandom_range(3, 0) == 0) step(int'($urandom_range(4, 1)));
        end
        issue(OP_RD, 32'd0, 32'd0, w);

        step(20);
        check("start_q_drained", start_q.size(), 0);
        check("rd_q_drained", rd_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #500000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench time limit");
    end
endmodule
